bip_control_unit: RTL and testbench

//  Multi-cycle control unit for the BIP accumulator CPU, generalising the combinational opcode decoder.

---
 rtl/bip_pkg.sv | 40 ++++
 rtl/bip_pc_reg.sv | 34 +++
 rtl/bip_control_unit.sv | 135 +++++++++++++
 tb/tb_bip_control_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP accumulator CPU: opcodes, control-unit states,
// datapath mux selections and the PC command set.
package bip_pkg;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;
  localparam logic [4:0] OPC_JMP  = 5'b01000;
  localparam logic [4:0] OPC_BEQ  = 5'b01001;
  localparam logic [4:0] OPC_BNE  = 5'b01010;

  localparam logic [1:0] SEL_A_ALU = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_MEM = 2'd2;
  localparam logic       SEL_B_MEM = 1'b0;
  localparam logic       SEL_B_IMM = 1'b1;
  localparam logic       OP_ADD    = 1'b1;
  localparam logic       OP_SUB    = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEMWAIT,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_CLEAR,
    PC_INC,
    PC_LOAD
  } pc_cmd_e;

endpackage

// File: rtl/bip_pc_reg.sv
// Program counter register with clear, increment (wrapping) and load commands.
module bip_pc_reg
  import bip_pkg::*;
#(
  parameter int PC_W = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  pc_cmd_e         i_cmd,
  input  logic [PC_W-1:0] i_load_val,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    unique case (i_cmd)
      PC_CLEAR: pc_d = '0;
      PC_INC:   pc_d = pc_q + PC_W'(1);
      PC_LOAD:  pc_d = i_load_val;
      default:  pc_d = pc_q;
    endcase
  end

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign o_pc = pc_q;

endmodule

// File: rtl/bip_control_unit.sv
// Multi-cycle BIP control unit: FETCH/EXEC/MEMWAIT sequencer with branches,
// halt/restart handshake and a configurable data-memory read latency.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int OPND_W   = 11,
  parameter int PC_W     = 11,
  parameter int RAM_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [OPND_W-1:0]   i_operand,
  input  logic                i_acc_zero,
  output logic [PC_W-1:0]     o_pc,
  output logic [1:0]          o_sel_a,
  output logic                o_sel_b,
  output logic                o_op,
  output logic                o_wr_acc,
  output logic                o_wr_ram,
  output logic                o_rd_ram,
  output logic                o_halted
);

  localparam int CNT_W = 2;

  if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_ram_lat
    $error("bip_control_unit: RAM_LAT must be within 1..4");
  end

  state_e              state_d, state_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic [OPCODE_W-1:0] memop_d, memop_q;
  pc_cmd_e             pc_cmd;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    memop_d  = memop_q;
    pc_cmd   = PC_HOLD;
    o_sel_a  = SEL_A_ALU;
    o_sel_b  = SEL_B_MEM;
    o_op     = OP_SUB;
    o_wr_acc = 1'b0;
    o_wr_ram = 1'b0;
    o_rd_ram = 1'b0;
    o_halted = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_FETCH;
          pc_cmd  = PC_CLEAR;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_cmd  = PC_INC;
        case (i_opcode)
          OPCODE_W'(OPC_HLT): begin
            state_d = ST_HALT;
            pc_cmd  = PC_HOLD;
          end
          OPCODE_W'(OPC_STO): o_wr_ram = 1'b1;
          OPCODE_W'(OPC_LDI): begin
            o_sel_a  = SEL_A_IMM;
            o_wr_acc = 1'b1;
          end
          OPCODE_W'(OPC_ADDI), OPCODE_W'(OPC_SUBI): begin
            o_sel_b  = SEL_B_IMM;
            o_op     = (i_opcode == OPCODE_W'(OPC_ADDI)) ? OP_ADD : OP_SUB;
            o_wr_acc = 1'b1;
          end
          OPCODE_W'(OPC_LD), OPCODE_W'(OPC_ADD), OPCODE_W'(OPC_SUB): begin
            o_rd_ram = 1'b1;
            cnt_d    = CNT_W'(RAM_LAT - 1);
            memop_d  = i_opcode;
            state_d  = ST_MEMWAIT;
            pc_cmd   = PC_HOLD;
          end
          OPCODE_W'(OPC_JMP): pc_cmd = PC_LOAD;
          OPCODE_W'(OPC_BEQ): pc_cmd = i_acc_zero ? PC_LOAD : PC_INC;
          OPCODE_W'(OPC_BNE): pc_cmd = i_acc_zero ? PC_INC : PC_LOAD;
          default: ;
        endcase
      end
      ST_MEMWAIT: begin
        o_rd_ram = 1'b1;
        if (cnt_q == '0) begin
          // Data memory output is valid now: commit it to ACC and move on.
          o_wr_acc = 1'b1;
          pc_cmd   = PC_INC;
          state_d  = ST_FETCH;
          if (memop_q == OPCODE_W'(OPC_LD)) o_sel_a = SEL_A_MEM;
          else if (memop_q == OPCODE_W'(OPC_ADD)) o_op = OP_ADD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HALT: begin
        o_halted = 1'b1;
        if (i_start) begin
          state_d = ST_FETCH;
          pc_cmd  = PC_CLEAR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      memop_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      memop_q <= memop_d;
    end
  end

  bip_pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .i_cmd      (pc_cmd),
    .i_load_val (PC_W'(i_operand)),
    .o_pc       (o_pc)
  );

endmodule

// File: tb/tb_bip_control_unit.sv
// Self-checking bench: three control units (RAM_LAT 1, 3, 4) run the same program
// memory and are compared every cycle against an instruction-level reference model.
module tb_bip_control_unit;

  localparam int NI = 3;
  localparam logic [4:0] T_HLT = 5'd0,  T_STO = 5'd1,  T_LD  = 5'd2,  T_LDI = 5'd3;
  localparam logic [4:0] T_ADD = 5'd4,  T_ADDI = 5'd5, T_SUB = 5'd6,  T_SUBI = 5'd7;
  localparam logic [4:0] T_JMP = 5'd8,  T_BEQ = 5'd9,  T_BNE = 5'd10, T_NOP = 5'd31;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  function automatic int lat_of(int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  logic clk = 1'b0;
  logic reset, i_start, i_acc_zero;
  logic [15:0] prog [2048];
  logic [7:0]  obs  [NI];
  logic [10:0] pcs  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [15:0] rdata;
    logic [10:0] pc;
    logic [1:0]  sel_a;
    logic        sel_b, op, wr_acc, wr_ram, rd_ram, halted;

    bip_control_unit #(.RAM_LAT(lat_of(g))) u_dut (
      .clk        (clk),
      .reset      (reset),
      .i_start    (i_start),
      .i_opcode   (rdata[15:11]),
      .i_operand  (rdata[10:0]),
      .i_acc_zero (i_acc_zero),
      .o_pc       (pc),
      .o_sel_a    (sel_a),
      .o_sel_b    (sel_b),
      .o_op       (op),
      .o_wr_acc   (wr_acc),
      .o_wr_ram   (wr_ram),
      .o_rd_ram   (rd_ram),
      .o_halted   (halted)
    );

    // Synchronous-read program memory, one read port per control unit.
    always @(posedge clk) rdata <= prog[pc];

    assign obs[g] = {halted, rd_ram, wr_ram, wr_acc, op, sel_b, sel_a};
    assign pcs[g] = pc;
  end

  // Reference model: run mode plus the cycle index k within the current instruction.
  int          m_mode [NI];
  int          m_k    [NI];
  logic [10:0] m_pc   [NI];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] ins(logic [4:0] opc, int opnd);
    return {opc, 11'(opnd)};
  endfunction

  function automatic bit is_mem(logic [4:0] opc);
    return (opc == T_LD) || (opc == T_ADD) || (opc == T_SUB);
  endfunction

  // Packed as {halted, rd_ram, wr_ram, wr_acc, op, sel_b, sel_a[1:0]}.
  function automatic logic [7:0] expected(int lat, int mode, int k, logic [15:0] w);
    logic [4:0] opc;
    logic h, rd, wrr, wra, o, sb;
    logic [1:0] sa;
    opc = w[15:11];
    {h, rd, wrr, wra, o, sb} = '0;
    sa = 2'd0;
    if (mode == M_HALT) h = 1'b1;
    else if (mode == M_RUN && k >= 1) begin
      if (k == 1) begin
        if (opc == T_STO) wrr = 1'b1;
        if (opc == T_LDI) begin sa = 2'd1; wra = 1'b1; end
        if (opc == T_ADDI) begin sb = 1'b1; o = 1'b1; wra = 1'b1; end
        if (opc == T_SUBI) begin sb = 1'b1; wra = 1'b1; end
      end
      if (is_mem(opc)) begin
        rd = 1'b1;
        if (k == 1 + lat) begin
          wra = 1'b1;
          if (opc == T_LD) sa = 2'd2;
          if (opc == T_ADD) o = 1'b1;
        end
      end
    end
    return {h, rd, wrr, wra, o, sb, sa};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_mode[i] = M_IDLE;
      m_k[i]    = 0;
      m_pc[i]   = '0;
    end
  endtask

  // Advances the model across the coming rising edge using the current inputs.
  task automatic model_advance();
    for (int i = 0; i < NI; i++) begin
      logic [15:0] w;
      int cost;
      w = prog[m_pc[i]];
      if (reset) begin
        m_mode[i] = M_IDLE; m_k[i] = 0; m_pc[i] = '0;
      end else if (m_mode[i] == M_IDLE || m_mode[i] == M_HALT) begin
        if (i_start) begin
          m_mode[i] = M_RUN; m_k[i] = 0; m_pc[i] = '0;
        end
      end else begin
        cost = is_mem(w[15:11]) ? 2 + lat_of(i) : 2;
        if (m_k[i] < cost - 1) m_k[i]++;
        else begin
          m_k[i] = 0;
          case (w[15:11])
            T_HLT: m_mode[i] = M_HALT;
            T_JMP: m_pc[i] = w[10:0];
            T_BEQ: m_pc[i] = i_acc_zero ? w[10:0] : m_pc[i] + 11'd1;
            T_BNE: m_pc[i] = i_acc_zero ? m_pc[i] + 11'd1 : w[10:0];
            default: m_pc[i] = m_pc[i] + 11'd1;
          endcase
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < NI; i++) begin
      logic [7:0] exp_o;
      exp_o = expected(lat_of(i), m_mode[i], m_k[i], prog[m_pc[i]]);
      vectors++;
      assert (obs[i] === exp_o) else begin
        miscompares++;
        $error("FAIL %s dut%0d outputs {halt,rd,wrram,wracc,op,selb,sela} got %b want %b",
               tag, i, obs[i], exp_o);
      end
      vectors++;
      assert (pcs[i] === m_pc[i]) else begin
        miscompares++;
        $error("FAIL %s dut%0d pc got %0d want %0d", tag, i, pcs[i], m_pc[i]);
      end
    end
  endtask

  task automatic step(logic start, logic zero, string tag);
    @(negedge clk);
    i_start = start;
    i_acc_zero = zero;
    #1;
    check_all(tag);
    model_advance();
  endtask

  // Asynchronous reset mid-cycle; i_start is held high while reset is active.
  task automatic do_reset(string tag);
    @(negedge clk);
    reset = 1'b1;
    i_start = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    model_advance();
    step(1'b1, 1'b0, tag);
    @(negedge clk);
    reset = 1'b0;
    i_start = 1'b0;
    #1;
    check_all(tag);
    model_advance();
  endtask

  initial begin
    reset = 1'b1;
    i_start = 1'b0;
    i_acc_zero = 1'b0;
    for (int a = 0; a < 2048; a++) prog[a] = ins(T_NOP, 0);
    model_reset();
    #2;
    check_all("por");

    // Straight-line program: LDI 5; ADDI 3; STO 7; HLT.
    prog[0] = ins(T_LDI, 5);
    prog[1] = ins(T_ADDI, 3);
    prog[2] = ins(T_STO, 7);
    prog[3] = ins(T_HLT, 0);
    step(1'b1, 1'b0, "start_in_reset");
    @(negedge clk);
    reset = 1'b0;
    i_start = 1'b0;
    #1;
    check_all("release");
    model_advance();
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, "idle");
    step(1'b1, 1'b0, "run1_start");
    for (int c = 0; c < 12; c++) step(1'b0, 1'b0, "run1");

    // Memory ops, branches, JMP to the top address and wrap through an unknown opcode.
    prog[0]    = ins(T_ADD, 9);
    prog[1]    = ins(T_BEQ, 20);
    prog[2]    = ins(T_BNE, 20);
    prog[3]    = ins(T_JMP, 2047);
    prog[20]   = ins(T_SUBI, 1);
    prog[21]   = ins(T_BEQ, 2);
    prog[22]   = ins(T_LD, 4);
    prog[23]   = ins(T_BNE, 3);
    prog[2047] = ins(T_NOP, 0);
    step(1'b1, 1'b0, "restart_from_halt");
    for (int c = 0; c < 120; c++)
      step(1'($urandom_range(0, 9) == 0), 1'($urandom), "branch_prog");

    // Random programs with sporadic restarts and resets.
    do_reset("reset_before_random");
    for (int a = 0; a < 2048; a++) begin
      int r;
      logic [4:0] opc;
      r = $urandom_range(0, 19);
      if (r <= 10)      opc = 5'(r);
      else if (r <= 13) opc = T_NOP;
      else              opc = 5'($urandom);
      prog[a] = {opc, 11'($urandom)};
    end
    step(1'b1, 1'b0, "random_start");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset("random_reset");
      else step(1'($urandom_range(0, 7) == 0), 1'($urandom), "random");
    end

    // Reset in the middle of a long data-memory wait.
    do_reset("pre_abort");
    prog[0] = ins(T_LD, 5);
    step(1'b1, 1'b0, "abort_start");
    step(1'b0, 1'b0, "abort_fetch");
    step(1'b0, 1'b0, "abort_exec");
    step(1'b0, 1'b0, "abort_memwait");
    do_reset("abort_reset");
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, "abort_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
